// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch front end.
package stopwatch_pkg;

    // Per-button debounce FSM state encoding
    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_PEND   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_PEND = 2'b11
    } btn_state_e;

    // 1 ms tick from the 1 MHz system clock
    localparam int unsigned TICK_DIV_DEFAULT    = 1000;
    localparam int unsigned DEBOUNCE_MS_DEFAULT = 10;
    localparam int unsigned HOLD_MS_DEFAULT     = 1000;
    localparam int unsigned N_BTN_DEFAULT       = 3;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM, hold counter.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   tick           shared ms tick from the prescaler
//   btn_raw        raw asynchronous button pin
//   btn_level      debounced level
//   press_pulse    1-cycle pulse on accepted press
//   release_pulse  1-cycle pulse on accepted release
//   hold_pulse     1-cycle pulse once per press after HOLD_MS ticks
module debounce_channel
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
    parameter int unsigned HOLD_MS     = HOLD_MS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_MS) + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_MS) + 1;
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_MS);

    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    btn_state_e        state_q, state_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_fired_q, hold_fired_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              hold_q, hold_d;
    logic              s;

    assign s = sync2_q;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            state_q      <= RELEASED;
            deb_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            hold_fired_q <= 1'b0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            hold_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            hold_fired_q <= hold_fired_d;
            level_q      <= level_d;
            press_q      <= press_d;
            release_q    <= release_d;
            hold_q       <= hold_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        state_d      = state_q;
        deb_cnt_d    = deb_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        hold_fired_d = hold_fired_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        hold_d       = 1'b0;

        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d   = PRESS_PEND;
                    deb_cnt_d = '0;
                end
            end
            PRESS_PEND: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (tick) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d      = PRESSED;
                        hold_cnt_d   = '0;
                        hold_fired_d = 1'b0;
                        press_d      = 1'b1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    end
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d   = RELEASE_PEND;
                    deb_cnt_d = '0;
                end else if (tick && (hold_cnt_q < HOLD_MAX)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RELEASE_PEND: begin
                // A bounce back high resumes the press with its hold progress intact
                if (s) begin
                    state_d = PRESSED;
                end else if (tick) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d   = RELEASED;
                        release_d = 1'b1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    end
                end
            end
            default: state_d = RELEASED;
        endcase

        // Hold fires once, the cycle after the saturating counter reaches its limit
        hold_d = !hold_fired_q && (hold_cnt_q == HOLD_MAX) && !release_d &&
                 ((state_q == PRESSED) || (state_q == RELEASE_PEND));
        if (hold_d) begin
            hold_fired_d = 1'b1;
        end

        level_d = (state_d == PRESSED) || (state_d == RELEASE_PEND);
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign hold_pulse    = hold_q;

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch push-button front end: shared ms prescaler plus N_BTN
// independent synchronise/debounce channels.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   btn_raw        raw asynchronous button pins, active high
//   btn_level      debounced button levels
//   press_pulse    1-cycle pulse per accepted press
//   release_pulse  1-cycle pulse per accepted release
//   hold_pulse     1-cycle pulse once per press after HOLD_MS ticks
//   tick           1-cycle ms tick for neighbouring blocks
module button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int unsigned N_BTN       = N_BTN_DEFAULT,
    parameter int unsigned TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT,
    parameter int unsigned HOLD_MS     = HOLD_MS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] hold_pulse,
    output logic             tick
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick_q, tick_d;

    // Free-running prescaler; tick is high while the count sits at its last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + PRE_W'(1);
        tick_d    = (pre_cnt_d == PRE_LAST);
    end

    assign tick = tick_q;

    // One debounce channel per button
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .HOLD_MS     (HOLD_MS)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .tick          (tick_q),
            .btn_raw       (btn_raw[i]),
            .btn_level     (btn_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .hold_pulse    (hold_pulse[i])
        );
    end

endmodule
